// File: rtl/xeng_tap_sched.sv
// Tap-chain scheduler for the X-engine: sequences antenna windows within a block,
// drives the accumulator reset and mux select, and reports finished windows after a fixed dump latency.
module xeng_tap_sched #(
   parameter int SERIAL_ACC_LEN_BITS = 7,
   parameter int N_ANTS              = 8,
   parameter int TAP_SEPARATION      = 1,
   parameter int DUMP_LATENCY        = 4,
   localparam int AB                 = $clog2(N_ANTS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           arm,
   input  logic                           disarm,
   input  logic                           sync_in,
   input  logic                           din_valid,
   output logic                           chain_rst,
   output logic [SERIAL_ACC_LEN_BITS-1:0] samp_idx,
   output logic [AB-1:0]                  ant_idx,
   output logic                           mux_end,
   output logic                           win_done,
   output logic [AB-1:0]                  dump_ant,
   output logic [31:0]                    block_cnt,
   output logic                           running,
   output logic                           err_gap,
   output logic                           err_resync
);

   localparam int FW = $clog2(DUMP_LATENCY + 1);
   localparam logic [SERIAL_ACC_LEN_BITS-1:0] SAMP_MAX = '1;
   localparam logic [AB-1:0] ANT_MAX = AB'(N_ANTS - 1);
   localparam logic [AB:0] TAP_SEP_W = (AB + 1)'(TAP_SEPARATION);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(DUMP_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t                           state_r, state_s;
   logic [FW-1:0]                    flush_cnt_r, flush_cnt_s;
   logic                             disarm_lat_r, disarm_lat_s;
   logic                             chain_rst_s;
   logic [SERIAL_ACC_LEN_BITS-1:0]   samp_s;
   logic [AB-1:0]                    ant_s;
   logic [31:0]                      block_cnt_s;
   logic                             err_gap_s, err_resync_s;
   logic                             win_end_s, block_end_s;
   logic [DUMP_LATENCY-1:0]          pipe_v_r;
   logic [DUMP_LATENCY-1:0][AB-1:0]  pipe_a_r;

   assign win_end_s   = (state_r == S_RUN) && (samp_idx == SAMP_MAX);
   assign block_end_s = win_end_s && (ant_idx == ANT_MAX);
   assign win_done    = pipe_v_r[DUMP_LATENCY-1];
   assign dump_ant    = pipe_a_r[DUMP_LATENCY-1];

   // Next-state and next-output decode; every output value describes the state it lands in.
   always_comb begin
      state_s      = state_r;
      flush_cnt_s  = flush_cnt_r;
      disarm_lat_s = disarm_lat_r;
      chain_rst_s  = 1'b0;
      samp_s       = samp_idx;
      ant_s        = ant_idx;
      block_cnt_s  = block_cnt;
      err_gap_s    = err_gap;
      err_resync_s = err_resync;
      case (state_r)
         S_IDLE: begin
            if (arm) begin
               state_s      = S_ARMED;
               err_gap_s    = 1'b0;
               err_resync_s = 1'b0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ARMED: begin
            if (disarm) begin
               state_s = S_IDLE;
            end else if (sync_in && din_valid) begin
               state_s     = S_RUN;
               chain_rst_s = 1'b1;
               samp_s      = '0;
               ant_s       = '0;
            end else begin
               state_s = S_ARMED;
            end
         end
         S_RUN: begin
            if (!din_valid) begin
               state_s      = S_ERR;
               err_gap_s    = 1'b1;
               chain_rst_s  = 1'b1;
               disarm_lat_s = 1'b0;
            end else if (sync_in && !block_end_s) begin
               err_resync_s = 1'b1;
               chain_rst_s  = 1'b1;
               samp_s       = '0;
               ant_s        = '0;
               disarm_lat_s = disarm_lat_r | disarm;
            end else begin
               samp_s = samp_idx + 1'b1;
               if (win_end_s) begin
                  ant_s = (ant_idx == ANT_MAX) ? '0 : ant_idx + 1'b1;
               end else begin
                  ant_s = ant_idx;
               end
               // A disarm seen on the boundary cycle itself still stops at this boundary.
               if (block_end_s) begin
                  block_cnt_s = block_cnt + 32'd1;
                  if (disarm_lat_r || disarm) begin
                     state_s      = S_FLUSH;
                     flush_cnt_s  = '0;
                     disarm_lat_s = 1'b0;
                  end else begin
                     disarm_lat_s = 1'b0;
                  end
               end else begin
                  disarm_lat_s = disarm_lat_r | disarm;
               end
            end
         end
         S_FLUSH: begin
            if (flush_cnt_r == FLUSH_LAST) begin
               state_s = S_IDLE;
            end else begin
               flush_cnt_s = flush_cnt_r + 1'b1;
            end
         end
         S_ERR: begin
            if (arm) begin
               state_s      = S_ARMED;
               err_gap_s    = 1'b0;
               err_resync_s = 1'b0;
            end else begin
               chain_rst_s = 1'b1;
            end
         end
         default: begin
            state_s     = S_IDLE;
            chain_rst_s = 1'b1;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_IDLE;
         flush_cnt_r  <= '0;
         disarm_lat_r <= 1'b0;
         chain_rst    <= 1'b1;
         samp_idx     <= '0;
         ant_idx      <= '0;
         mux_end      <= 1'b0;
         block_cnt    <= 32'd0;
         running      <= 1'b0;
         err_gap      <= 1'b0;
         err_resync   <= 1'b0;
      end else begin
         state_r      <= state_s;
         flush_cnt_r  <= flush_cnt_s;
         disarm_lat_r <= disarm_lat_s;
         chain_rst    <= chain_rst_s;
         samp_idx     <= samp_s;
         ant_idx      <= ant_s;
         mux_end      <= (state_s == S_RUN) && ({1'b0, ant_s} < TAP_SEP_W);
         block_cnt    <= block_cnt_s;
         running      <= (state_s == S_RUN);
         err_gap      <= err_gap_s;
         err_resync   <= err_resync_s;
      end
   end

   // Dump pipeline: runs in every state so windows closed before a stop still report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v_r <= '0;
         pipe_a_r <= '0;
      end else begin
         pipe_v_r[0] <= win_end_s;
         pipe_a_r[0] <= ant_idx;
         for (int i = 1; i < DUMP_LATENCY; i++) begin
            pipe_v_r[i] <= pipe_v_r[i-1];
            pipe_a_r[i] <= pipe_a_r[i-1];
         end
      end
   end

endmodule

// File: doc/xeng_tap_sched.md
XENG_TAP_SCHED -- requirements
Module: xeng_tap_sched

Interface
REQ-001 SHALL have parameter SERIAL_ACC_LEN_BITS, default 7: serial accumulation length, equal to 2^SERIAL_ACC_LEN_BITS samples per window.
REQ-002 SHALL have parameter N_ANTS, default 8: antennas per block; power of 2, at least 2.
REQ-003 SHALL have parameter TAP_SEPARATION, default 1: number of leading windows per block with mux_end asserted.
REQ-004 SHALL have parameter DUMP_LATENCY, default 4: cycles from window end to win_done; at least 1.
REQ-005 SHALL have these ports, clock and reset first; AB = log2(N_ANTS):
- clk  in  1  single clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  start request pulse; also clears error flags.
- disarm  in  1  stop request pulse; stop takes effect at the next block boundary.
- sync_in  in  1  block sync; the first sample arrives on the following cycle.
- din_valid  in  1  input sample valid; must stay continuous while running.
- chain_rst  out  1  accumulator sync/reset to the tap chain.
- samp_idx  out  SERIAL_ACC_LEN_BITS  sample index within the current window.
- ant_idx  out  AB  window (antenna) index within the block.
- mux_end  out  1  selects the a_end input in the taps.
- win_done  out  1  one-cycle pulse marking a completed window.
- dump_ant  out  AB  ant_idx of the window being reported by win_done.
- block_cnt  out  32  completed blocks; wraps modulo 2^32.
- running  out  1  high while the state is RUN.
- err_gap  out  1  sticky: din_valid dropped during RUN.
- err_resync  out  1  sticky: sync_in arrived off a block boundary.

Function
REQ-006 SHALL have states IDLE, ARMED, RUN, FLUSH and ERR, with all outputs registered.
REQ-007 IDLE: on arm, SHALL go to ARMED, clearing err_gap and err_resync; otherwise stay in IDLE.
REQ-008 ARMED: on sync_in=1 with din_valid=1 at cycle t, SHALL enter RUN at t+1 with chain_rst=1 for exactly that one cycle and samp_idx=0, ant_idx=0.
REQ-009 RUN counting: samp_idx SHALL increment each cycle and wrap from 2^SERIAL_ACC_LEN_BITS-1 to 0; ant_idx SHALL increment on each samp_idx wrap and wrap from N_ANTS-1 to 0.
REQ-010 RUN block count: when samp_idx=max and ant_idx=N_ANTS-1, block_cnt SHALL increment on the next cycle.
REQ-011 mux_end SHALL equal (ant_idx < TAP_SEPARATION) in RUN, and SHALL be 0 in every other state.
REQ-012 For every cycle in RUN with samp_idx=max, win_done SHALL be 1 exactly DUMP_LATENCY cycles later with dump_ant equal to that cycle's ant_idx; this is a shift pipeline that keeps advancing in every state.
REQ-013 sync_in during RUN on a block boundary (samp_idx=max, ant_idx=N_ANTS-1) SHALL have no effect other than normal wrap; no error, no chain_rst.
REQ-014 sync_in during RUN off a block boundary SHALL set err_resync, pulse chain_rst for one cycle, and restart with samp_idx=0, ant_idx=0 on the next cycle; block_cnt is unchanged.
REQ-015 din_valid=0 during RUN SHALL set err_gap and go to ERR on the next cycle. Gap takes priority over a simultaneous sync_in.
REQ-016 ERR SHALL hold chain_rst=1 and freeze the counters. On arm, it SHALL go to ARMED and clear both error flags.
REQ-017 disarm in RUN SHALL be latched; the block completes, and after the boundary cycle the state SHALL be FLUSH.
REQ-018 FLUSH SHALL last exactly DUMP_LATENCY cycles so the pending win_done pulses drain, then go to IDLE.
REQ-019 disarm in ARMED SHALL return to IDLE; disarm in IDLE or ERR SHALL be ignored. arm outside IDLE and ERR SHALL be ignored.
REQ-020 running SHALL be 1 only in RUN.

Reset
REQ-021 rst=1 SHALL asynchronously force: state IDLE; chain_rst=1; samp_idx, ant_idx, mux_end, win_done, dump_ant all 0; block_cnt=0; err flags 0; dump pipeline cleared; latched disarm cleared.
REQ-022 chain_rst SHALL drop to 0 on the first clock after rst deasserts. Reset mid-RUN SHALL abandon the block, with no win_done for the partial window.

Verification
All scenarios use SERIAL_ACC_LEN_BITS=2, N_ANTS=4, TAP_SEPARATION=1, DUMP_LATENCY=3.
REQ-023 Basic run: arm, then sync_in with din_valid at t -> chain_rst=1 only at t+1; samp_idx 0,1,2,3,0...; ant_idx steps every 4 cycles; mux_end=1 for t+1..t+4; win_done at t+7 with dump_ant=0.
REQ-024 Block wrap: run 16 valid cycles -> block_cnt=1 at t+17; ant_idx=0 and samp_idx=0 at t+17; win_done seen 4 times with dump_ant 0,1,2,3.
REQ-025 Resync: sync_in at samp_idx=1, ant_idx=2 -> err_resync=1, chain_rst one pulse, counters 0/0 next cycle; sync_in at 3/3 -> no error.
REQ-026 Gap: din_valid=0 in RUN -> ERR next cycle, err_gap=1, chain_rst held 1; arm -> ARMED, flags 0.
REQ-027 Stop: disarm at samp_idx=0, ant_idx=1 -> block completes, FLUSH 3 cycles, last win_done has dump_ant=3, then IDLE.
REQ-028 Async reset: rst pulsed between clock edges mid-RUN -> outputs reach reset values immediately, with no win_done afterwards.
